lbs_master: RTL and testbench

Local-bus initiator: the master end of the 16-bit asynchronous DSP EMIF-style local bus that the board's slave decoder serves. Accepts single-word read/write requests on a valid/ready interface and generates chip-select, read/write, output-enable and write-enable strobes with parameterised setup, strobe, hold and turnaround phases. Returns captured read data or a write completion on a one-cycle response strobe. Used as a board self-test initiator and as a behavioural driver for bench-level checks of the slave bus.

---
 rtl/lbs_pkg.sv | 23 ++
 rtl/lbs_master_if.sv | 36 +++
 rtl/sync_2ff.sv | 24 ++
 rtl/lbs_master.sv | 191 +++++++++++++++++++
 tb/tb_lbs_master.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbs_pkg.sv
// Shared types and constants for the local-bus initiator: FSM states,
// bus widths and default phase timing.
package lbs_pkg;

   localparam int LBS_AW      = 12;
   localparam int LBS_DW      = 16;
   localparam int PHASE_W     = 6;

   localparam int DEF_SETUP   = 2;
   localparam int DEF_STROBE  = 4;
   localparam int DEF_HOLD    = 1;
   localparam int DEF_TURN    = 2;
   localparam int DEF_TIMEOUT = 1023;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD,
      ST_TURN
   } lbs_state_e;

endpackage

// File: rtl/lbs_master_if.sv
// Request/response handshake and local-bus pins of the initiator, with the
// initiator (master) and requester/bus-peer (slave) views.
interface lbs_master_if;
   import lbs_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_rw_n;
   logic [LBS_AW-1:0] req_addr;
   logic [LBS_DW-1:0] req_wdata;
   logic              rsp_valid;
   logic [LBS_DW-1:0] rsp_rdata;
   logic              rsp_err;
   logic [LBS_AW-1:0] lbs_addr;
   logic [LBS_DW-1:0] lbs_dout;
   logic              lbs_dout_en;
   logic [LBS_DW-1:0] lbs_din;
   logic              lbs_cs_n;
   logic              lbs_rw_n;
   logic              lbs_oe_n;
   logic              lbs_we_n;
   logic              lbs_wait;

   modport master (
      input  req_valid, req_rw_n, req_addr, req_wdata, lbs_din, lbs_wait,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             lbs_addr, lbs_dout, lbs_dout_en, lbs_cs_n, lbs_rw_n, lbs_oe_n, lbs_we_n
   );

   modport slave (
      output req_valid, req_rw_n, req_addr, req_wdata, lbs_din, lbs_wait,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             lbs_addr, lbs_dout, lbs_dout_en, lbs_cs_n, lbs_rw_n, lbs_oe_n, lbs_we_n
   );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_reg;
   logic sync_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_reg <= 1'b0;
         sync_reg <= 1'b0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/lbs_master.sv
// Local-bus initiator: single-word EMIF-style read/write cycles with setup,
// strobe, hold and turnaround phases. Define LBS_MASTER_WAIT_EN for slave wait.
module lbs_master
   import lbs_pkg::*;
#(
   parameter int SETUP   = DEF_SETUP,
   parameter int STROBE  = DEF_STROBE,
   parameter int HOLD    = DEF_HOLD,
   parameter int TURN    = DEF_TURN,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int U_DLY   = 1
) (
   input logic          clk,
   input logic          rst,
   lbs_master_if.master bus
);

`ifdef LBS_MASTER_WAIT_EN
   localparam int STROBE_MIN = 3;
`else
   localparam int STROBE_MIN = 1;
`endif

   generate
      if (SETUP < 1 || SETUP > 15 || STROBE < STROBE_MIN || STROBE > 63 ||
          HOLD < 1 || HOLD > 15 || TURN < 0 || TURN > 15 || TIMEOUT < 1 || U_DLY < 0) begin : g_bad_params
         $error("lbs_master: timing parameter out of range");
      end
   endgenerate

   lbs_state_e          state_reg;
   logic [PHASE_W-1:0]  cnt_reg;
   logic                rw_reg;
   logic                err_reg;
   logic                req_ready_reg;
   logic                rsp_valid_reg;
   logic                rsp_err_reg;
   logic [LBS_DW-1:0]   rsp_rdata_reg;
   logic [LBS_AW-1:0]   addr_reg;
   logic [LBS_DW-1:0]   dout_reg;
   logic                dout_en_reg;
   logic                cs_n_reg;
   logic                rw_n_reg;
   logic                oe_n_reg;
   logic                we_n_reg;
   logic                strobe_extend;
   logic                strobe_timeout;
   logic                accept;

   assign accept = bus.req_valid && req_ready_reg;

`ifdef LBS_MASTER_WAIT_EN
   localparam int EXT_W = $clog2(TIMEOUT + 1);
   logic             wait_sync;
   logic [EXT_W-1:0] ext_cnt_reg;

   sync_2ff u_wait_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.lbs_wait),
      .q   (wait_sync)
   );

   assign strobe_timeout = wait_sync && (ext_cnt_reg == EXT_W'(TIMEOUT));
   assign strobe_extend  = wait_sync && !strobe_timeout;
`else
   assign strobe_timeout = 1'b0;
   assign strobe_extend  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         rw_reg        <= 1'b1;
         err_reg       <= 1'b0;
         req_ready_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_rdata_reg <= '0;
         addr_reg      <= '0;
         dout_reg      <= '0;
         dout_en_reg   <= 1'b0;
         cs_n_reg      <= 1'b1;
         rw_n_reg      <= 1'b1;
         oe_n_reg      <= 1'b1;
         we_n_reg      <= 1'b1;
`ifdef LBS_MASTER_WAIT_EN
         ext_cnt_reg   <= '0;
`endif
      end else begin
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               req_ready_reg <= 1'b1;
               if (accept) begin
                  state_reg     <= ST_SETUP;
                  cnt_reg       <= PHASE_W'(SETUP - 1);
                  req_ready_reg <= 1'b0;
                  rw_reg        <= bus.req_rw_n;
                  err_reg       <= 1'b0;
                  addr_reg      <= bus.req_addr;
                  dout_reg      <= bus.req_wdata;
                  dout_en_reg   <= !bus.req_rw_n;
                  cs_n_reg      <= 1'b0;
                  rw_n_reg      <= bus.req_rw_n;
               end
            end
            ST_SETUP: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - PHASE_W'(1);
               end else begin
                  state_reg <= ST_STROBE;
                  cnt_reg   <= PHASE_W'(STROBE - 1);
                  oe_n_reg  <= !rw_reg;
                  we_n_reg  <= rw_reg;
`ifdef LBS_MASTER_WAIT_EN
                  ext_cnt_reg <= '0;
`endif
               end
            end
            ST_STROBE: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - PHASE_W'(1);
               end else if (strobe_extend) begin
`ifdef LBS_MASTER_WAIT_EN
                  ext_cnt_reg <= ext_cnt_reg + EXT_W'(1);
`endif
               end else begin
                  // This edge is the read sample point; a timed-out read keeps old data.
                  state_reg <= ST_HOLD;
                  cnt_reg   <= PHASE_W'(HOLD - 1);
                  oe_n_reg  <= 1'b1;
                  we_n_reg  <= 1'b1;
                  err_reg   <= strobe_timeout;
                  if (rw_reg && !strobe_timeout)
                     rsp_rdata_reg <= bus.lbs_din;
                  if (HOLD == 1) begin
                     rsp_valid_reg <= 1'b1;
                     rsp_err_reg   <= strobe_timeout;
                  end
               end
            end
            ST_HOLD: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - PHASE_W'(1);
                  if (cnt_reg == PHASE_W'(1)) begin
                     rsp_valid_reg <= 1'b1;
                     rsp_err_reg   <= err_reg;
                  end
               end else begin
                  cs_n_reg    <= 1'b1;
                  rw_n_reg    <= 1'b1;
                  dout_en_reg <= 1'b0;
                  // The IDLE cycle is the last turnaround cycle, so TURN state lasts TURN-1.
                  if (TURN > 1) begin
                     state_reg <= ST_TURN;
                     cnt_reg   <= PHASE_W'(TURN - 2);
                  end else begin
                     state_reg     <= ST_IDLE;
                     req_ready_reg <= 1'b1;
                  end
               end
            end
            ST_TURN: begin
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - PHASE_W'(1);
               end else begin
                  state_reg     <= ST_IDLE;
                  req_ready_reg <= 1'b1;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready   = req_ready_reg;
   assign bus.rsp_valid   = rsp_valid_reg;
   assign bus.rsp_err     = rsp_err_reg;
   assign bus.rsp_rdata   = rsp_rdata_reg;
   assign bus.lbs_addr    = addr_reg;
   assign bus.lbs_dout    = dout_reg;
   assign bus.lbs_dout_en = dout_en_reg;
   assign bus.lbs_cs_n    = cs_n_reg;
   assign bus.lbs_rw_n    = rw_n_reg;
   assign bus.lbs_oe_n    = oe_n_reg;
   assign bus.lbs_we_n    = we_n_reg;

endmodule

// File: tb/tb_lbs_master.sv
// Bench for lbs_master: table vectors, random traffic against a memory model
// of the slave, and hand sequences for back-to-back, reset and wait cases.
module tb_lbs_master;
   import lbs_pkg::*;

   localparam int SETUP  = DEF_SETUP;
   localparam int STROBE = DEF_STROBE;
   localparam int HOLD   = DEF_HOLD;
   localparam int TURN   = DEF_TURN;
`ifdef LBS_MASTER_WAIT_EN
   localparam int TIMEOUT = 8;
`else
   localparam int TIMEOUT = DEF_TIMEOUT;
`endif
   // cs_n is high for at least one cycle (the IDLE accept cycle) between cycles.
   localparam int GAP = (TURN < 1) ? 1 : TURN;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   txn_no = 0;

   lbs_master_if bus ();

   lbs_master #(
      .SETUP   (SETUP),
      .STROBE  (STROBE),
      .HOLD    (HOLD),
      .TURN    (TURN),
      .TIMEOUT (TIMEOUT),
      .U_DLY   (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Slave memory model: unwritten words read back a fixed address hash.
   function automatic logic [15:0] seed_val(input logic [11:0] a);
      return 16'(a * 16'h9E37) ^ 16'h5AA5;
   endfunction

   logic [15:0] slave_mem [0:4095];
   bit   [4095:0] written;

   assign bus.lbs_din = !bus.lbs_oe_n ?
                        (written[bus.lbs_addr] ? slave_mem[bus.lbs_addr] : seed_val(bus.lbs_addr)) :
                        16'hDEAD;

   always @(posedge clk) begin
      if (!bus.lbs_we_n && !bus.lbs_cs_n && bus.lbs_dout_en) begin
         slave_mem[bus.lbs_addr] <= bus.lbs_dout;
         written[bus.lbs_addr]   <= 1'b1;
      end
   end

   // Reference model of the slave contents and of the held read data.
   logic [15:0] ref_mem [int];
   logic [15:0] last_rd = 16'h0000;

   function automatic logic [15:0] model_read(input logic [11:0] a);
      return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : seed_val(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One request; cycle 0 is the accept cycle, outputs sampled on falling edges.
   // lbs_wait is high in cycles w_lo..w_hi (or random when rand_wait is set).
   task automatic do_txn(input logic rw, input logic [11:0] a, input logic [15:0] d,
                         input logic [15:0] exp_rd, input int w_lo, input int w_hi,
                         input bit rand_wait, output int st_len, output logic got_err);
      int   waited = 0;
      int   cs_first = -1, cs_last = -1, st_first = -1, st_last = -1;
      int   other_low = 0, rsp_cnt = 0, rsp_cyc = -1, bad_bus = 0, ready_early = 0;
      logic ready_final = 1'b0;
      logic [15:0] got_rd = 16'h0;
      int   exp_last, exp_idle;
      logic exp_err;
      logic strobe_n, other_n;

      got_err  = 1'b0;
      st_len   = 0;
      exp_last = SETUP + STROBE;
      exp_err  = 1'b0;
`ifdef LBS_MASTER_WAIT_EN
      // Synchronized wait lags the pin by two cycles; each late high adds a strobe cycle.
      while ((exp_last - 2) >= w_lo && (exp_last - 2) <= w_hi) begin
         if (exp_last - (SETUP + STROBE) == TIMEOUT) begin
            exp_err = 1'b1;
            break;
         end
         exp_last++;
      end
`endif
      exp_idle = exp_last + HOLD + GAP;

      @(negedge clk);
      while (!bus.req_ready && waited < 60) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.req_ready) begin
         check("ready_wait_bound", 32'(bus.req_ready), 32'd1);
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_rw_n  = rw;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.lbs_wait  = 1'b0;

      for (int k = 1; k <= exp_idle; k++) begin
         @(negedge clk);
         if (k == 1) bus.req_valid = 1'b0;
         strobe_n = rw ? bus.lbs_oe_n : bus.lbs_we_n;
         other_n  = rw ? bus.lbs_we_n : bus.lbs_oe_n;
         if (!bus.lbs_cs_n) begin
            if (cs_first < 0) cs_first = k;
            cs_last = k;
            if (bus.lbs_addr !== a || bus.lbs_rw_n !== rw || bus.lbs_dout_en !== ~rw ||
                (!rw && bus.lbs_dout !== d))
               bad_bus++;
         end else if (bus.lbs_dout_en || !bus.lbs_rw_n || !bus.lbs_oe_n || !bus.lbs_we_n) begin
            bad_bus++;
         end
         if (!strobe_n) begin
            if (st_first < 0) st_first = k;
            st_last = k;
            st_len++;
         end
         if (!other_n) other_low++;
         if (bus.rsp_valid) begin
            rsp_cnt++;
            rsp_cyc = k;
            got_rd  = bus.rsp_rdata;
            got_err = bus.rsp_err;
         end
         if (k < exp_idle && bus.req_ready) ready_early++;
         if (k == exp_idle) ready_final = bus.req_ready;
         bus.lbs_wait = rand_wait ? 1'($urandom_range(0, 1)) : (k >= w_lo && k <= w_hi);
      end
      bus.lbs_wait = 1'b0;

      check("cs_window",    32'((cs_first << 8) | cs_last), 32'((1 << 8) | (exp_last + HOLD)));
      check("strobe_window", 32'((st_first << 8) | st_last), 32'(((SETUP + 1) << 8) | exp_last));
      check("other_strobe_low", 32'(other_low), 32'd0);
      check("bus_hold", 32'(bad_bus), 32'd0);
      check("rsp_count", 32'(rsp_cnt), 32'd1);
      check("rsp_cycle", 32'(rsp_cyc), 32'(exp_last + HOLD));
      check("rsp_err", 32'(got_err), 32'(exp_err));
      check("rsp_rdata", 32'(got_rd), 32'(exp_rd));
      check("ready_return", 32'({ready_early[7:0], 7'd0, ready_final}), 32'd1);
      txn_no++;
      $display("txn %0d %s addr=0x%03h wdata=0x%04h rdata=0x%04h err=%0d strobe=%0d",
               txn_no, rw ? "RD" : "WR", a, d, got_rd, got_err, st_len);
   endtask

   typedef struct {
      logic        rw;
      logic [11:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_rdata;
   } vec_t;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs [7];
      int          st_len;
      logic        got_err;
      logic [11:0] a;
      logic [15:0] d, exp;
      logic        rw;
      int          acc [2];
      int          n_acc;
      logic        cs_hist [0:29];
      int          gap, idx;
      int          rsp_seen;

      vecs[0] = '{1'b0, 12'h123, 16'hA5C3, 16'h0000};
      vecs[1] = '{1'b1, 12'h000, 16'h0000, 16'h5AA5};
      vecs[2] = '{1'b0, 12'h7FF, 16'h1234, 16'h5AA5};
      vecs[3] = '{1'b1, 12'h123, 16'h0000, 16'hA5C3};
      vecs[4] = '{1'b1, 12'h7FF, 16'h0000, 16'h1234};
      vecs[5] = '{1'b0, 12'h000, 16'hFFFF, 16'h1234};
      vecs[6] = '{1'b1, 12'h000, 16'h0000, 16'hFFFF};

      bus.req_valid = 1'b0;
      bus.req_rw_n  = 1'b1;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.lbs_wait  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err}), 32'd0);
      check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      check("rst_strobes", 32'({bus.lbs_cs_n, bus.lbs_rw_n, bus.lbs_oe_n, bus.lbs_we_n}), 32'hF);
      check("rst_addr", 32'(bus.lbs_addr), 32'd0);
      check("rst_dout", 32'({bus.lbs_dout_en, bus.lbs_dout}), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(bus.req_ready), 32'd1);

      // Table vectors
      foreach (vecs[i]) begin
         do_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 1, 0, 1'b0, st_len, got_err);
         if (vecs[i].rw) last_rd = vecs[i].exp_rdata;
         else            ref_mem[int'(vecs[i].addr)] = vecs[i].wdata;
      end

      // Back-to-back writes with req_valid held high
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_rw_n  = 1'b0;
      bus.req_addr  = 12'h055;
      bus.req_wdata = 16'h0F0F;
      n_acc = 0;
      acc[0] = -1;
      acc[1] = -1;
      for (int c = 0; c < 30; c++) begin
         if (c > 0) @(negedge clk);
         if (n_acc == 2) bus.req_valid = 1'b0;
         cs_hist[c] = bus.lbs_cs_n;
         if (bus.req_valid && bus.req_ready && n_acc < 2) begin
            acc[n_acc] = c;
            n_acc++;
         end
      end
      ref_mem[int'(12'h055)] = 16'h0F0F;
      check("b2b_accepts", 32'(n_acc), 32'd2);
      check("b2b_period", 32'(acc[1] - acc[0]), 32'(SETUP + STROBE + HOLD + GAP));
      idx = 0;
      while (idx < 30 && cs_hist[idx]) idx++;
      while (idx < 30 && !cs_hist[idx]) idx++;
      gap = 0;
      while (idx < 30 && cs_hist[idx]) begin
         gap++;
         idx++;
      end
      check("b2b_cs_gap", 32'(gap), 32'(GAP));
      $display("txn b2b accepts at %0d and %0d, cs_n high gap %0d", acc[0], acc[1], gap);

      // Random traffic against the reference model
      for (int i = 0; i < 40; i++) begin
         rw = 1'($urandom_range(0, 1));
         a  = 12'($urandom_range(0, 4095));
         if ($urandom_range(0, 1) == 1) a = 12'($urandom_range(0, 7));
         d  = 16'($urandom);
         exp = rw ? model_read(a) : last_rd;
`ifdef LBS_MASTER_WAIT_EN
         do_txn(rw, a, d, exp, 1, 0, 1'b0, st_len, got_err);
`else
         do_txn(rw, a, d, exp, 1, 0, 1'b1, st_len, got_err);
`endif
         if (rw) last_rd = exp;
         else    ref_mem[int'(a)] = d;
      end

      // Reset in the strobe phase of a read
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_rw_n  = 1'b1;
      bus.req_addr  = 12'h123;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (SETUP + 1) @(negedge clk);
      check("mid_rst_in_strobe", 32'(bus.lbs_oe_n), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_strobes", 32'({bus.lbs_cs_n, bus.lbs_rw_n, bus.lbs_oe_n, bus.lbs_we_n}), 32'hF);
      check("mid_rst_dout_en", 32'(bus.lbs_dout_en), 32'd0);
      rsp_seen = 0;
      for (int c = 0; c < 14; c++) begin
         if (bus.rsp_valid) rsp_seen++;
         if (c == 1) rst = 1'b0;
         @(negedge clk);
      end
      check("mid_rst_no_rsp", 32'(rsp_seen), 32'd0);
      check("mid_rst_ready", 32'(bus.req_ready), 32'd1);
      last_rd = 16'h0000;
      $display("txn reset during read strobe, rsp pulses seen %0d", rsp_seen);

`ifdef LBS_MASTER_WAIT_EN
      // Wait high in cycles 2..6: synchronized wait covers three extra strobe cycles.
      exp = model_read(12'h321);
      do_txn(1'b1, 12'h321, 16'h0, exp, 2, 6, 1'b0, st_len, got_err);
      check("wait5_strobe_len", 32'(st_len), 32'(STROBE + 3));
      check("wait5_err", 32'(got_err), 32'd0);
      last_rd = exp;
      // Permanent wait: extended by TIMEOUT cycles then an error response.
      do_txn(1'b1, 12'h322, 16'h0, last_rd, 2, 1000, 1'b0, st_len, got_err);
      check("timeout_strobe_len", 32'(st_len), 32'(STROBE + TIMEOUT));
      check("timeout_err", 32'(got_err), 32'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
